// File: rtl/color_bbox_scanner_pkg.sv
// Shared constants for the colour bounding-box scanner: FSM encoding,
// channel positions inside a packed {R,G,B} pixel and default frame size.
package color_bbox_scanner_pkg;

    localparam int unsigned DEF_H_RES = 320;
    localparam int unsigned DEF_V_RES = 240;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CH_B   = 0;
    localparam int unsigned CH_G   = 1;
    localparam int unsigned CH_R   = 2;

    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_SCAN  = 2'd1;
    localparam logic [ST_W-1:0] ST_DRAIN = 2'd2;
    localparam logic [ST_W-1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/color_bbox_scanner_if.sv
// Control, frame-buffer read port and result bus of the colour bbox scanner.
// min_hits exists only when COLOR_BBOX_NOISE_FILTER_EN is defined.
interface color_bbox_scanner_if #(
    parameter int unsigned CH_W   = 4,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned XY_W   = 9
) ();
    logic                start;
    logic                ack;
    logic [3*CH_W-1:0]   thr_lo;
    logic [3*CH_W-1:0]   thr_hi;
`ifdef COLOR_BBOX_NOISE_FILTER_EN
    logic [ADDR_W-1:0]   min_hits;
`endif
    logic [ADDR_W-1:0]   rd_addr;
    logic [3*CH_W-1:0]   rd_data;
    logic [XY_W-1:0]     x_min;
    logic [XY_W-1:0]     x_max;
    logic [XY_W-1:0]     y_min;
    logic [XY_W-1:0]     y_max;
    logic [ADDR_W-1:0]   hit_count;
    logic                found;
    logic                busy;
    logic                done;

    // Environment side: processor registers plus frame-buffer read data.
    modport master (
        output start, ack, thr_lo, thr_hi, rd_data,
`ifdef COLOR_BBOX_NOISE_FILTER_EN
               min_hits,
`endif
        input  rd_addr, x_min, x_max, y_min, y_max, hit_count, found, busy, done
    );

    modport slave (
        input  start, ack, thr_lo, thr_hi, rd_data,
`ifdef COLOR_BBOX_NOISE_FILTER_EN
               min_hits,
`endif
        output rd_addr, x_min, x_max, y_min, y_max, hit_count, found, busy, done
    );

endinterface

// File: rtl/color_window_match.sv
// Combinational per-channel inclusive window compare on a packed {R,G,B} pixel.
module color_window_match
    import color_bbox_scanner_pkg::*;
#(
    parameter int unsigned CH_W = 4
) (
    input  logic [3*CH_W-1:0] pix,
    input  logic [3*CH_W-1:0] lo,
    input  logic [3*CH_W-1:0] hi,
    output logic              hit_c
);

    logic [NUM_CH-1:0] ch_ok;

    // An inverted window (lo > hi) can never satisfy both bounds.
    always_comb begin
        ch_ok = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            ch_ok[c] = (pix[c*CH_W +: CH_W] >= lo[c*CH_W +: CH_W]) &&
                       (pix[c*CH_W +: CH_W] <= hi[c*CH_W +: CH_W]);
        end
    end

    assign hit_c = &ch_ok;

endmodule

// File: rtl/color_bbox_scanner.sv
// Raster-scans a frame buffer and reports bbox/hit count of pixels inside an
// RGB window. Optional minimum-hit qualification: COLOR_BBOX_NOISE_FILTER_EN.
module color_bbox_scanner
    import color_bbox_scanner_pkg::*;
#(
    parameter int unsigned H_RES  = DEF_H_RES,
    parameter int unsigned V_RES  = DEF_V_RES,
    parameter int unsigned CH_W   = 4,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned XY_W   = 9
) (
    input logic clk,
    input logic reset,
    color_bbox_scanner_if.slave bus
);

    localparam int unsigned PIX_W = 3 * CH_W;
    localparam int unsigned DRN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    logic [ST_W-1:0]   state, state_nxt;
    logic              take_start, do_latch, do_ack;
    logic              scan_last, drain_last;
    logic              pix_hit_c, tap_hit, found_c;

    logic [PIX_W-1:0]  thr_lo_q, thr_hi_q;
    logic [XY_W-1:0]   x_cnt, y_cnt;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [DRN_W-1:0]  drain_cnt;

    logic [RD_LAT-1:0] dl_vld;
    logic [XY_W-1:0]   dl_x [RD_LAT];
    logic [XY_W-1:0]   dl_y [RD_LAT];

    logic [XY_W-1:0]   acc_xmin, acc_xmax, acc_ymin, acc_ymax;
    logic [ADDR_W-1:0] acc_cnt;

    logic [XY_W-1:0]   x_min_q, x_max_q, y_min_q, y_max_q;
    logic [ADDR_W-1:0] hit_count_q;
    logic              found_q, busy_q, done_q;

    assign scan_last  = (x_cnt == XY_W'(H_RES - 1)) && (y_cnt == XY_W'(V_RES - 1));
    assign drain_last = (drain_cnt == DRN_W'(RD_LAT - 1));

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // DONE spends its first cycle latching results; done rises with them.
    always_comb begin
        state_nxt  = state;
        take_start = 1'b0;
        do_latch   = 1'b0;
        do_ack     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt  = ST_SCAN;
                    take_start = 1'b1;
                end
            end
            ST_SCAN:  if (scan_last)  state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_last) state_nxt = ST_DONE;
            ST_DONE: begin
                if (!done_q) begin
                    do_latch = 1'b1;
                end else if (bus.ack) begin
                    state_nxt = ST_IDLE;
                    do_ack    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            thr_lo_q <= '0;
            thr_hi_q <= '0;
        end else if (take_start) begin
            thr_lo_q <= bus.thr_lo;
            thr_hi_q <= bus.thr_hi;
        end
    end

    // Raster address walk; address holds on the last pixel after the scan.
    always_ff @(posedge clk) begin
        if (!reset) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            rd_addr_q <= '0;
            drain_cnt <= '0;
        end else begin
            if (take_start) begin
                x_cnt     <= '0;
                y_cnt     <= '0;
                rd_addr_q <= '0;
            end else if ((state == ST_SCAN) && !scan_last) begin
                rd_addr_q <= rd_addr_q + ADDR_W'(1);
                if (x_cnt == XY_W'(H_RES - 1)) begin
                    x_cnt <= '0;
                    y_cnt <= y_cnt + XY_W'(1);
                end else begin
                    x_cnt <= x_cnt + XY_W'(1);
                end
            end
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DRN_W'(1) : '0;
        end
    end

    // Coordinate tags travel alongside the read so they meet rd_data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dl_vld <= '0;
        end else begin
            dl_vld[0] <= (state == ST_SCAN);
            for (int unsigned i = 1; i < RD_LAT; i++) dl_vld[i] <= dl_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        dl_x[0] <= x_cnt;
        dl_y[0] <= y_cnt;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            dl_x[i] <= dl_x[i-1];
            dl_y[i] <= dl_y[i-1];
        end
    end

    color_window_match #(.CH_W(CH_W)) u_match (
        .pix   (bus.rd_data),
        .lo    (thr_lo_q),
        .hi    (thr_hi_q),
        .hit_c (pix_hit_c)
    );

    assign tap_hit = dl_vld[RD_LAT-1] && pix_hit_c;

    always_ff @(posedge clk) begin
        if (!reset || take_start) begin
            acc_xmin <= XY_W'(H_RES - 1);
            acc_xmax <= '0;
            acc_ymin <= XY_W'(V_RES - 1);
            acc_ymax <= '0;
            acc_cnt  <= '0;
        end else if (tap_hit) begin
            if (dl_x[RD_LAT-1] < acc_xmin) acc_xmin <= dl_x[RD_LAT-1];
            if (dl_x[RD_LAT-1] > acc_xmax) acc_xmax <= dl_x[RD_LAT-1];
            if (dl_y[RD_LAT-1] < acc_ymin) acc_ymin <= dl_y[RD_LAT-1];
            if (dl_y[RD_LAT-1] > acc_ymax) acc_ymax <= dl_y[RD_LAT-1];
            acc_cnt <= acc_cnt + ADDR_W'(1);
        end
    end

`ifdef COLOR_BBOX_NOISE_FILTER_EN
    logic [ADDR_W-1:0] min_hits_q;

    always_ff @(posedge clk) begin
        if (!reset)          min_hits_q <= '0;
        else if (take_start) min_hits_q <= bus.min_hits;
    end

    assign found_c = (acc_cnt >= min_hits_q);
`else
    assign found_c = (acc_cnt != '0);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            x_min_q     <= '0;
            x_max_q     <= '0;
            y_min_q     <= '0;
            y_max_q     <= '0;
            hit_count_q <= '0;
            found_q     <= 1'b0;
        end else if (do_latch) begin
            x_min_q     <= found_c ? acc_xmin : '0;
            x_max_q     <= found_c ? acc_xmax : '0;
            y_min_q     <= found_c ? acc_ymin : '0;
            y_max_q     <= found_c ? acc_ymax : '0;
            hit_count_q <= acc_cnt;
            found_q     <= found_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_nxt == ST_SCAN) || (state_nxt == ST_DRAIN);
            if (do_latch)    done_q <= 1'b1;
            else if (do_ack) done_q <= 1'b0;
        end
    end

    assign bus.rd_addr   = rd_addr_q;
    assign bus.x_min     = x_min_q;
    assign bus.x_max     = x_max_q;
    assign bus.y_min     = y_min_q;
    assign bus.y_max     = y_max_q;
    assign bus.hit_count = hit_count_q;
    assign bus.found     = found_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_color_bbox_scanner.sv
// Scoreboard bench for color_bbox_scanner on an 8x4 frame with a 2-cycle
// frame-buffer model; noise-filter cases follow COLOR_BBOX_NOISE_FILTER_EN.
module tb_color_bbox_scanner;
    import color_bbox_scanner_pkg::*;

    localparam int unsigned H    = 8;
    localparam int unsigned V    = 4;
    localparam int unsigned LAT  = 2;
    localparam int unsigned CW   = 4;
    localparam int unsigned AW   = 17;
    localparam int unsigned XW   = 9;
    localparam int unsigned NPIX = H * V;
    localparam int unsigned AI   = $clog2(NPIX);
    localparam int unsigned PW   = 3 * CW;

    typedef struct {
        int xmin, xmax, ymin, ymax, cnt, found, lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    int            n_cmp = 0;
    int            n_err = 0;
    logic [PW-1:0] fb      [NPIX];
    logic [PW-1:0] rd_pipe [LAT];
    exp_t          sb_q[$];
    exp_t          prev;
    logic [PW-1:0] lo_g, hi_g, bg, green;

    color_bbox_scanner_if #(.CH_W(CW), .ADDR_W(AW), .XY_W(XW)) bus ();

    color_bbox_scanner #(
        .H_RES(H), .V_RES(V), .CH_W(CW), .RD_LAT(LAT), .ADDR_W(AW), .XY_W(XW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Frame buffer with LAT cycles of read latency.
    always @(posedge clk) begin
        rd_pipe[0] <= fb[bus.rd_addr[AI-1:0]];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.rd_data = rd_pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] pix(input int r, input int g, input int b);
        logic [PW-1:0] p;
        p = '0;
        p[CH_R*CW +: CW] = CW'(r);
        p[CH_G*CW +: CW] = CW'(g);
        p[CH_B*CW +: CW] = CW'(b);
        return p;
    endfunction

    function automatic int eff_thr(input int mh);
`ifdef COLOR_BBOX_NOISE_FILTER_EN
        return mh;
`else
        return (mh == mh) ? 1 : 1;
`endif
    endfunction

    // Reference: brute-force over the frame buffer contents.
    function automatic exp_t model(input logic [PW-1:0] lo, input logic [PW-1:0] hi, input int thr);
        exp_t e;
        int   xmn, xmx, ymn, ymx, cnt;
        bit   ok;
        logic [CW-1:0] pc, lc, hc;
        logic [PW-1:0] p;
        xmn = H; xmx = -1; ymn = V; ymx = -1; cnt = 0;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                p  = fb[y*H + x];
                ok = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    pc = p[c*CW +: CW];
                    lc = lo[c*CW +: CW];
                    hc = hi[c*CW +: CW];
                    if (pc < lc || pc > hc) ok = 1'b0;
                end
                if (ok) begin
                    cnt++;
                    if (x < xmn) xmn = x;
                    if (x > xmx) xmx = x;
                    if (y < ymn) ymn = y;
                    if (y > ymx) ymx = y;
                end
            end
        end
        e.cnt   = cnt;
        e.found = (cnt >= thr) ? 1 : 0;
        e.xmin  = e.found ? xmn : 0;
        e.xmax  = e.found ? xmx : 0;
        e.ymin  = e.found ? ymn : 0;
        e.ymax  = e.found ? ymx : 0;
        e.lat   = 1 + NPIX + LAT + 1;
        return e;
    endfunction

    task automatic fill_bg();
        for (int i = 0; i < NPIX; i++) fb[i] = bg;
    endtask

    task automatic run_frame(input string tag, input logic [PW-1:0] lo, input logic [PW-1:0] hi,
                             input int mh, input bit ack_start);
        exp_t          g;
        int            cyc;
        logic [AW-1:0] mx;
        sb_q.push_back(model(lo, hi, eff_thr(mh)));
        @(negedge clk);
        bus.thr_lo = lo;
        bus.thr_hi = hi;
        bus.start  = 1'b1;
`ifdef COLOR_BBOX_NOISE_FILTER_EN
        bus.min_hits = AW'(mh);
`endif
        @(negedge clk);
        // Scramble live inputs: the scan must use the values taken at start.
        bus.start  = 1'b0;
        bus.thr_lo = ~lo;
        bus.thr_hi = ~hi;
`ifdef COLOR_BBOX_NOISE_FILTER_EN
        bus.min_hits = '0;
`endif
        cyc = 1;
        mx  = '0;
        chk({tag, " busy"}, 32'(bus.busy), 1);
        chk({tag, " hold_cnt"}, 32'(bus.hit_count), prev.cnt);
        while (!bus.done && cyc < 200) begin
            if (bus.rd_addr > mx) mx = bus.rd_addr;
            @(negedge clk);
            cyc++;
        end
        g = sb_q.pop_front();
        chk({tag, " latency"}, cyc, g.lat);
        chk({tag, " max_addr"}, 32'(mx), NPIX - 1);
        chk({tag, " x_min"}, 32'(bus.x_min), g.xmin);
        chk({tag, " x_max"}, 32'(bus.x_max), g.xmax);
        chk({tag, " y_min"}, 32'(bus.y_min), g.ymin);
        chk({tag, " y_max"}, 32'(bus.y_max), g.ymax);
        chk({tag, " hit_count"}, 32'(bus.hit_count), g.cnt);
        chk({tag, " found"}, 32'(bus.found), g.found);
        prev = g;
        bus.ack   = 1'b1;
        bus.start = ack_start;
        @(negedge clk);
        bus.ack   = 1'b0;
        bus.start = 1'b0;
        chk({tag, " done_clr"}, 32'(bus.done), 0);
        repeat (3) @(negedge clk);
        chk({tag, " idle_busy"}, 32'(bus.busy), 0);
        chk({tag, " hold_xmax"}, 32'(bus.x_max), g.xmax);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.ack    = 1'b0;
        bus.thr_lo = '0;
        bus.thr_hi = '0;
`ifdef COLOR_BBOX_NOISE_FILTER_EN
        bus.min_hits = AW'(1);
`endif
        bg    = pix(15, 2, 1);
        green = pix(0, 14, 0);
        lo_g  = pix(0, 13, 0);
        hi_g  = pix(7, 15, 7);
        prev  = '{default: 0};
        fill_bg();

        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst busy", 32'(bus.busy), 0);
        chk("rst done", 32'(bus.done), 0);
        chk("rst found", 32'(bus.found), 0);
        chk("rst hit_count", 32'(bus.hit_count), 0);
        chk("rst x_max", 32'(bus.x_max), 0);
        chk("rst y_max", 32'(bus.y_max), 0);
        chk("rst rd_addr", 32'(bus.rd_addr), 0);

        fb[1*H + 2] = green;
        fb[1*H + 5] = green;
        fb[3*H + 3] = green;
        run_frame("green", lo_g, hi_g, 1, 1'b0);

        fill_bg();
        run_frame("none", lo_g, hi_g, 1, 1'b0);

        fb[NPIX-1] = green;
        run_frame("corner", lo_g, hi_g, 1, 1'b0);

        fill_bg();
        fb[2*H + 4] = pix(0, 15, 0);
        run_frame("exact", lo_g, hi_g, 1, 1'b0);
        run_frame("inverted", pix(8, 13, 0), hi_g, 1, 1'b0);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NPIX; i++) fb[i] = PW'($urandom);
            run_frame("random", pix($urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 8)),
                      pix($urandom_range(6, 15), $urandom_range(6, 15), $urandom_range(6, 15)), 1, 1'b0);
        end

        fill_bg();
        fb[1*H + 2] = green;
        fb[1*H + 5] = green;
        fb[3*H + 3] = green;
        run_frame("noise", lo_g, hi_g, 4, 1'b1);

        // Abort a scan with a one-cycle reset pulse.
        @(negedge clk);
        bus.thr_lo = lo_g;
        bus.thr_hi = hi_g;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort busy", 32'(bus.busy), 0);
        chk("abort rd_addr", 32'(bus.rd_addr), 0);
        chk("abort hit_count", 32'(bus.hit_count), 0);
        chk("abort x_max", 32'(bus.x_max), 0);
        @(negedge clk);
        chk("abort stays idle", 32'(bus.busy), 0);
        prev = '{default: 0};
        run_frame("recover", lo_g, hi_g, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
